// File: rtl/page_pkg.sv
// -----------------------------------------------------------------------------
// page_pkg
// Shared definitions for the page replay stub: default packet width, the
// position of the packet valid bit, the replay state enum and a packet type.
// -----------------------------------------------------------------------------
package page_pkg;

   // Default packet width; the MSB of a packet is its valid flag.
   localparam int PAGE_DATA_W = 49;
   localparam int VALID_BIT   = PAGE_DATA_W - 1;

   // Controller states: capturing in IDLE, draining the ring in REPLAY.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } page_state_t;

   // A packet at the default width.
   typedef logic [PAGE_DATA_W-1:0] page_packet_t;

endpackage : page_pkg

// File: rtl/page_ring_mem.sv
// -----------------------------------------------------------------------------
// page_ring_mem
// DEPTH x DATA_W register array backing the replay ring. One synchronous
// write port and one combinational read port. The array is deliberately not
// reset: a flush only rewinds the pointers, and stale entries are never read
// because the controller only addresses slots that hold live packets.
//
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write slot index (0..DEPTH-1)
//   i_wdata  in   packet to store
//   i_raddr  in   read slot index (0..DEPTH-1)
//   o_rdata  out  packet stored at i_raddr (combinational)
// -----------------------------------------------------------------------------
module page_ring_mem
   import page_pkg::*;
#(
   parameter int DATA_W = PAGE_DATA_W,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Store one packet per cycle at the write slot.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : page_ring_mem

// File: rtl/page_replay_buffer.sv
// -----------------------------------------------------------------------------
// page_replay_buffer
// Leaf-side page stub. Records the most recent valid BFT packets in a ring of
// DEPTH entries and, on a resend request, replays them oldest first with
// out_ready backpressure. Replays are non-destructive; a flush rewinds the
// ring. Valid packets that cannot be captured are counted in a saturating
// drop counter.
//
// Ports:
//   clk                      in   clock
//   reset                    in   synchronous active-high reset
//   din_leaf_bft2interface   in   packet from the BFT, valid when MSB = 1
//   resend                   in   replay request, sampled while idle
//   flush                    in   discard all stored packets
//   out_ready                in   leaf interface accepts dout this cycle
//   dout_leaf_interface2bft  out  replayed packet, zero when none presented
//   occupancy                out  number of stored packets
//   busy                     out  high while replaying
//   replay_done              out  one-cycle pulse when a replay finishes
//   drop_cnt                 out  saturating count of uncaptured valid packets
// -----------------------------------------------------------------------------
module page_replay_buffer
   import page_pkg::*;
#(
   parameter int DATA_W = PAGE_DATA_W,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            din_leaf_bft2interface,
   input  logic                         resend,
   input  logic                         flush,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            dout_leaf_interface2bft,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         busy,
   output logic                         replay_done,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);
   // Wide enough to hold wr_ptr + DEPTH - occupancy without overflow.
   localparam int SW = OW + 1;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Advance a ring index, wrapping from DEPTH-1 back to 0.
   function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
      logic [AW-1:0] v;
      if (p == AW'(DEPTH - 1)) begin
         v = {AW{1'b0}};
      end else begin
         v = p + AW'(1);
      end
      return v;
   endfunction

   // Oldest live slot: (wr - occ) mod DEPTH, done without a modulo operator.
   function automatic logic [AW-1:0] start_idx(input logic [AW-1:0] wr,
                                               input logic [OW-1:0] occ);
      logic [SW-1:0] v;
      v = SW'(wr) + SW'(DEPTH) - SW'(occ);
      if (v >= SW'(DEPTH)) begin
         v = v - SW'(DEPTH);
      end else begin
         v = v;
      end
      return v[AW-1:0];
   endfunction

   // Increment the drop counter, holding at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] v;
      if (c == {CNT_W{1'b1}}) begin
         v = c;
      end else begin
         v = c + CNT_W'(1);
      end
      return v;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   page_state_t       r_state;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [OW-1:0]     r_occ;
   logic [OW-1:0]     r_rem;
   logic [DATA_W-1:0] r_dout;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_drop;
   logic              r_flush_pend;

   page_state_t       w_state_next;
   logic [AW-1:0]     w_wr_next;
   logic [AW-1:0]     w_rd_next;
   logic [OW-1:0]     w_occ_next;
   logic [OW-1:0]     w_rem_next;
   logic [DATA_W-1:0] w_dout_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic [CNT_W-1:0]  w_drop_next;
   logic              w_pend_next;

   logic              w_valid;
   logic              w_flush_eff;
   logic              w_cap_we;
   logic [AW-1:0]     w_cap_wr;
   logic [OW-1:0]     w_cap_occ;
   logic [AW-1:0]     w_start;
   logic [AW-1:0]     w_rd_inc;
   logic [AW-1:0]     w_raddr;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] w_first;

   assign w_valid     = din_leaf_bft2interface[DATA_W-1];
   // A flush requested during a replay is applied on the first idle cycle.
   assign w_flush_eff = flush | r_flush_pend;

   // Capture/flush effect on the write pointer and occupancy while idle.
   always_comb begin
      w_cap_we  = 1'b0;
      w_cap_wr  = r_wr_ptr;
      w_cap_occ = r_occ;
      if (r_state == IDLE) begin
         if (w_flush_eff) begin
            w_cap_wr  = {AW{1'b0}};
            w_cap_occ = {OW{1'b0}};
         end else if (w_valid) begin
            w_cap_we = 1'b1;
            w_cap_wr = inc_ptr(r_wr_ptr);
            if (r_occ == OW'(DEPTH)) begin
               w_cap_occ = r_occ;
            end else begin
               w_cap_occ = r_occ + OW'(1);
            end
         end else begin
            w_cap_we = 1'b0;
         end
      end else begin
         w_cap_we = 1'b0;
      end
   end

   // Replay starts from the oldest slot counted after this cycle's capture,
   // so a packet arriving together with resend is part of the replay.
   assign w_start  = start_idx(w_cap_wr, w_cap_occ);
   assign w_rd_inc = inc_ptr(r_rd_ptr);
   assign w_raddr  = (r_state == REPLAY) ? w_rd_inc : w_start;

   page_ring_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_cap_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (din_leaf_bft2interface),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // If the ring was empty the first replayed packet is the one being
   // written this same cycle, which the array does not show yet.
   assign w_first = (w_cap_we && (w_start == r_wr_ptr)) ? din_leaf_bft2interface
                                                         : w_rdata;

   // Next-state and next-output logic for the capture/replay controller.
   always_comb begin
      w_state_next = r_state;
      w_wr_next    = r_wr_ptr;
      w_occ_next   = r_occ;
      w_rd_next    = r_rd_ptr;
      w_rem_next   = r_rem;
      w_dout_next  = r_dout;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      w_drop_next  = r_drop;
      w_pend_next  = r_flush_pend;
      case (r_state)
         IDLE: begin
            w_wr_next   = w_cap_wr;
            w_occ_next  = w_cap_occ;
            w_dout_next = {DATA_W{1'b0}};
            w_busy_next = 1'b0;
            w_pend_next = 1'b0;
            // Flush wins over a same-cycle packet, which is then lost.
            if (w_flush_eff && w_valid) begin
               w_drop_next = sat_inc(r_drop);
            end else begin
               w_drop_next = r_drop;
            end
            if (resend) begin
               if (w_cap_occ != {OW{1'b0}}) begin
                  w_state_next = REPLAY;
                  w_rd_next    = w_start;
                  w_rem_next   = w_cap_occ;
                  w_busy_next  = 1'b1;
                  w_dout_next  = w_first;
               end else begin
                  w_done_next = 1'b1;
               end
            end else begin
               w_state_next = IDLE;
            end
         end
         REPLAY: begin
            // Capture is frozen while replaying; incoming packets are lost.
            if (w_valid) begin
               w_drop_next = sat_inc(r_drop);
            end else begin
               w_drop_next = r_drop;
            end
            if (flush) begin
               w_pend_next = 1'b1;
            end else begin
               w_pend_next = r_flush_pend;
            end
            if (out_ready) begin
               w_rd_next  = w_rd_inc;
               w_rem_next = r_rem - OW'(1);
               if (r_rem == OW'(1)) begin
                  w_state_next = IDLE;
                  w_dout_next  = {DATA_W{1'b0}};
                  w_busy_next  = 1'b0;
                  w_done_next  = 1'b1;
               end else begin
                  w_dout_next = w_rdata;
               end
            end else begin
               w_dout_next = r_dout;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_dout_next  = {DATA_W{1'b0}};
            w_busy_next  = 1'b0;
         end
      endcase
   end

   // Controller registers with synchronous reset; reset aborts any replay.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wr_ptr     <= {AW{1'b0}};
         r_rd_ptr     <= {AW{1'b0}};
         r_occ        <= {OW{1'b0}};
         r_rem        <= {OW{1'b0}};
         r_dout       <= {DATA_W{1'b0}};
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_drop       <= {CNT_W{1'b0}};
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_wr_ptr     <= w_wr_next;
         r_rd_ptr     <= w_rd_next;
         r_occ        <= w_occ_next;
         r_rem        <= w_rem_next;
         r_dout       <= w_dout_next;
         r_busy       <= w_busy_next;
         r_done       <= w_done_next;
         r_drop       <= w_drop_next;
         r_flush_pend <= w_pend_next;
      end
   end

   assign dout_leaf_interface2bft = r_dout;
   assign occupancy               = r_occ;
   assign busy                    = r_busy;
   assign replay_done             = r_done;
   assign drop_cnt                = r_drop;

endmodule : page_replay_buffer

// File: tb/tb_page_replay_buffer.sv
// -----------------------------------------------------------------------------
// tb_page_replay_buffer
// Self-checking bench for page_replay_buffer (DEPTH=5 to exercise wrap,
// CNT_W=2 to exercise drop saturation). A queue-based reference model tracks
// the stored packets, the remaining replay list and the drop count; every
// cycle all DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_page_replay_buffer;

   localparam int DW  = 49;
   localparam int DEP = 5;
   localparam int CW  = 2;
   localparam int OW  = $clog2(DEP + 1);

   logic          clk;
   logic          reset;
   logic [DW-1:0] din;
   logic          resend;
   logic          flush;
   logic          out_ready;
   logic [DW-1:0] dout;
   logic [OW-1:0] occupancy;
   logic          busy;
   logic          replay_done;
   logic [CW-1:0] drop_cnt;

   int n_cmp;
   int n_err;

   // Reference model state
   logic [DW-1:0] m_store[$];
   logic [DW-1:0] m_pend[$];
   bit            m_replay;
   bit            m_fpend;
   int            m_drop;
   logic [DW-1:0] exp_dout;
   bit            exp_busy;
   bit            exp_done;

   page_replay_buffer #(
      .DATA_W (DW),
      .DEPTH  (DEP),
      .CNT_W  (CW)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_bft2interface  (din),
      .resend                  (resend),
      .flush                   (flush),
      .out_ready               (out_ready),
      .dout_leaf_interface2bft (dout),
      .occupancy               (occupancy),
      .busy                    (busy),
      .replay_done             (replay_done),
      .drop_cnt                (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit expired before summary");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rand_pkt(input bit v);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      return {v, a[15:0], b};
   endfunction

   task automatic drop_one();
      if (m_drop < (1 << CW) - 1) m_drop++;
   endtask

   // Apply the rules of one clock edge to the model, using the inputs held
   // during the cycle that just ended.
   task automatic model_update();
      bit v;
      v = din[DW-1];
      exp_done = 1'b0;
      if (reset) begin
         m_store.delete();
         m_pend.delete();
         m_replay = 1'b0;
         m_fpend  = 1'b0;
         m_drop   = 0;
         exp_dout = '0;
         exp_busy = 1'b0;
      end else if (!m_replay) begin
         if (flush || m_fpend) begin
            m_store.delete();
            m_fpend = 1'b0;
            if (v) drop_one();
         end else if (v) begin
            m_store.push_back(din);
            if (m_store.size() > DEP) void'(m_store.pop_front());
         end
         exp_dout = '0;
         exp_busy = 1'b0;
         if (resend) begin
            if (m_store.size() > 0) begin
               m_pend   = m_store;
               m_replay = 1'b1;
               exp_dout = m_pend[0];
               exp_busy = 1'b1;
            end else begin
               exp_done = 1'b1;
            end
         end
      end else begin
         if (v) drop_one();
         if (flush) m_fpend = 1'b1;
         if (out_ready) begin
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) begin
               m_replay = 1'b0;
               exp_dout = '0;
               exp_busy = 1'b0;
               exp_done = 1'b1;
            end else begin
               exp_dout = m_pend[0];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
      chk("dout",        64'(dout),        64'(exp_dout));
      chk("busy",        64'(busy),        64'(exp_busy));
      chk("replay_done", 64'(replay_done), 64'(exp_done));
      chk("occupancy",   64'(occupancy),   64'(m_store.size()));
      chk("drop_cnt",    64'(drop_cnt),    64'(m_drop));
   endtask

   task automatic cyc(input bit v, input bit rs, input bit fl, input bit rdy);
      din       = rand_pkt(v);
      resend    = rs;
      flush     = fl;
      out_ready = rdy;
      tick();
   endtask

   initial begin
      bit pat [4];
      n_cmp = 0;
      n_err = 0;
      m_replay = 1'b0;
      m_fpend  = 1'b0;
      m_drop   = 0;
      exp_dout = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      din = '0; resend = 1'b0; flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);

      // Reset state
      reset = 1'b1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      reset = 1'b0;

      // Three packets then a full-speed replay
      repeat (3) cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
      repeat (5) cyc(0, 0, 0, 1);

      // Overfill the ring so it wraps, replay keeps only the newest DEPTH
      cyc(0, 0, 1, 1);
      repeat (7) cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
      repeat (7) cyc(0, 0, 0, 1);

      // Backpressure: out_ready 1,0,0,1,...
      cyc(0, 0, 1, 1);
      repeat (4) cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, pat[i % 4]);

      // Packets during replay are dropped; second resend replays same set
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (6) cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      repeat (6) cyc(0, 0, 0, 1);

      // Empty resend
      cyc(0, 0, 1, 1);
      cyc(0, 1, 0, 1);
      repeat (2) cyc(0, 0, 0, 1);

      // Flush after five captures, then same-cycle flush and valid din
      repeat (5) cyc(1, 0, 0, 1);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 1, 1);
      cyc(0, 0, 0, 1);

      // Resend with a capture in the same cycle from empty
      cyc(1, 1, 0, 1);
      repeat (3) cyc(0, 0, 0, 1);

      // Drop counter saturation
      cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 0);
      repeat (6) cyc(1, 0, 0, 0);
      repeat (5) cyc(0, 0, 0, 1);

      // Flush requested mid-replay takes effect after the replay
      repeat (3) cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
      cyc(0, 0, 1, 1);
      repeat (5) cyc(0, 0, 0, 1);

      // Reset in the middle of a replay
      repeat (4) cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      reset = 1'b1;
      cyc(0, 0, 0, 1);
      reset = 1'b0;
      repeat (3) cyc(0, 0, 0, 1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(199, 0) == 0);
         cyc($urandom_range(1, 0) == 1,
             $urandom_range(9, 0) == 0,
             $urandom_range(29, 0) == 0,
             $urandom_range(9, 0) < 7);
      end
      reset = 1'b0;
      repeat (10) cyc(0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_page_replay_buffer

// File: doc/page_replay_buffer.md
# page_replay_buffer

Parametrised leaf-side page stub that records the most recent valid BFT packets arriving at a page and replays them, oldest first, on a resend request. It replaces the single-packet echo register between the BFT leaf interface and the page logic. It adds depth, backpressure from the leaf interface, flush, and status reporting. It is non-destructive: one capture can be replayed any number of times.

## Interface
Parameters:
- DATA_W, 49: packet width. Bit DATA_W-1 is the packet valid bit.
- DEPTH, 8: number of stored packets, ≥2. Need not be a power of two.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- din_leaf_bft2interface  in  DATA_W  packet from the BFT. It is captured when bit DATA_W-1 = 1.
- resend  in  1  replay request, level-sampled in IDLE.
- flush  in  1  discards all stored packets.
- out_ready  in  1  the leaf interface accepts dout this cycle.
- dout_leaf_interface2bft  out  DATA_W  replayed packet. It is all-zero when no packet is presented.
- occupancy  out  $clog2(DEPTH+1)  number of stored packets.
- busy  out  1  high while in REPLAY.
- replay_done  out  1  one-cycle pulse at the end of a replay.
- drop_cnt  out  CNT_W  count of valid packets not captured. It saturates at all-ones.

## Operation
- Storage is a ring of DEPTH entries with write pointer wr_ptr and count occupancy.
- Both pointers wrap explicitly from DEPTH-1 to 0.
- Oldest entry index = (wr_ptr − occupancy) mod DEPTH.
- State machine: IDLE, REPLAY.
- IDLE capture:
  - A valid din is written at wr_ptr and wr_ptr advances.
  - occupancy increments, saturating at DEPTH.
  - When the ring is full, the oldest entry is overwritten.
- IDLE, resend=1:
  - If occupancy>0: load rd_ptr with the oldest index and a remaining count of occupancy, then go to REPLAY.
  - If occupancy=0: stay in IDLE and pulse replay_done on the next cycle.
- REPLAY:
  - dout presents mem[rd_ptr].
  - When out_ready=1, the packet is accepted, rd_ptr advances and remaining decrements.
  - When out_ready=0, dout holds its value.
  - After the last packet is accepted: dout becomes 0, return to IDLE, replay_done pulses.
- During REPLAY, valid din is not captured; each such packet increments drop_cnt. resend is ignored.
- flush:
  - In IDLE: occupancy becomes 0 and wr_ptr becomes 0. The data array is not cleared.
  - In REPLAY: flush is deferred until the cycle after return to IDLE.
- In IDLE, flush and a valid din in the same cycle: flush wins and the packet is counted as dropped.
- In IDLE, resend and a valid din in the same cycle: the packet is captured first, and the replay includes it.
- Replay does not modify occupancy or the array contents.

## Timing
- Reset values: dout=0, occupancy=0, busy=0, replay_done=0, drop_cnt=0, state=IDLE, pointers=0.
- Reset mid-replay aborts the replay immediately. No replay_done is generated.
- Capture latency: valid din in cycle t → occupancy updated in cycle t+1.
- Replay latency: resend sampled in cycle t → busy=1 and the first packet on dout in cycle t+1. All outputs are registered.
- Throughput is one packet per cycle with out_ready held high. N packets occupy cycles t+1..t+N, with busy=0 and replay_done=1 in cycle t+N+1.
- An empty resend in cycle t → replay_done=1 in cycle t+1, busy stays 0.

## Structure
- Package page_pkg holds:
  - the default DATA_W;
  - VALID_BIT = DATA_W-1;
  - the state enum {IDLE, REPLAY};
  - a packet typedef.
- Sub-module page_ring_mem holds the DEPTH×DATA_W register array with one write port and one combinational read port.
- page_replay_buffer holds the pointers, counters, FSM and output register.

## Test plan
- Reset, 3 valid packets A,B,C, resend with out_ready=1 → dout=A,B,C on cycles t+1..t+3, replay_done at t+4, occupancy=3.
- DEPTH=8, write 10 packets P0..P9, resend → replay P2..P9 and occupancy=8. DEPTH=5 exercises wrap.
- Replay of 4 packets with out_ready toggling 1,0,0,1,... → each packet held until accepted, no loss or duplication.
- 2 valid din during REPLAY → drop_cnt=2, occupancy unchanged. A second resend replays the original set.
- Empty resend → replay_done at t+1, busy never high. flush after 5 captures → occupancy=0. Same-cycle flush and valid din → drop_cnt+1.
- Reset asserted mid-replay → all outputs 0 next cycle, no replay_done. drop_cnt saturation with CNT_W=2 → stays at 3.
